// File: rtl/sys_bridge.sv
// sys_bridge: decodes CPU M-stage accesses onto data memory, timer channels and the
// interrupt-acknowledge window, and hosts the interrupt mask/pending and bus-error block.
module sys_bridge #(
  parameter int          N_TIMER    = 2,
  parameter logic [31:0] DM_BASE    = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT   = 32'h0000_2FFF,
  parameter logic [31:0] TMR_BASE   = 32'h0000_7F00,
  parameter logic [31:0] TMR_STRIDE = 32'h0000_0010,
  parameter logic [31:0] INT_BASE   = 32'h0000_7F20,
  parameter logic [31:0] INT_LIMIT  = 32'h0000_7F23,
  parameter logic [31:0] CTL_BASE   = 32'h0000_7F40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_byteen,
  input  logic                    cpu_rd,
  input  logic                    req,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_rvalid,
  output logic [5:0]              HWInt,
  output logic [31:0]             m_data_addr,
  output logic [31:0]             m_data_wdata,
  output logic [3:0]              m_data_byteen,
  input  logic [31:0]             m_data_rdata,
  output logic [30*N_TIMER-1:0]   tmr_addr,
  output logic [32*N_TIMER-1:0]   tmr_din,
  output logic [N_TIMER-1:0]      tmr_we,
  input  logic [32*N_TIMER-1:0]   tmr_dout,
  input  logic [N_TIMER-1:0]      tmr_irq,
  input  logic                    int_irq,
  output logic [31:0]             m_int_addr,
  output logic [3:0]              m_int_byteen
);

  typedef enum logic [2:0] {SEL_NONE, SEL_DM, SEL_TMR, SEL_INT, SEL_CTL} sel_e;

  // Single unsigned compare, so a region based at address zero needs no special case.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr - base) <= (limit - base);
  endfunction

  sel_e               sel_s;
  sel_e               sel_r;
  logic [N_TIMER-1:0] tmr_hit_vec_s;
  logic [1:0]         tmr_idx_s;
  logic [1:0]         tmr_idx_r;
  logic               access_s;
  logic               wr_s;
  logic               rd_s;
  logic               err_s;
  logic               ctl_wr_s;
  logic [1:0]         ctl_off_s;
  logic [31:0]        ctl_rd_s;
  logic [31:0]        ctl_r;
  logic               rvalid_r;
  logic [31:0]        tmr_rdata_s;
  logic [5:0]         src_s;
  logic [5:0]         src_r;
  logic [5:0]         ipend_set_s;
  logic [5:0]         ipend_clr_s;
  logic [5:0]         imask_r;
  logic [5:0]         ipend_r;
  logic [31:0]        erraddr_r;
  logic [15:0]        errcnt_r;

  for (genvar k = 0; k < N_TIMER; k++) begin : g_tmr
    assign tmr_hit_vec_s[k] = in_range(cpu_addr, TMR_BASE + 32'(k) * TMR_STRIDE,
                                       TMR_BASE + 32'(k + 1) * TMR_STRIDE - 32'd1);
    assign tmr_we[k]        = wr_s & (sel_s == SEL_TMR) & (tmr_idx_s == 2'(k));
  end

  assign m_data_addr  = cpu_addr;
  assign m_data_wdata = cpu_wdata;
  assign m_int_addr   = cpu_addr;
  assign tmr_addr     = {N_TIMER{cpu_addr[31:2]}};
  assign tmr_din      = {N_TIMER{cpu_wdata}};

  // Region decode; walking timers downward leaves the lowest matching channel selected.
  always_comb begin
    tmr_idx_s = 2'd0;
    for (int k = N_TIMER - 1; k >= 0; k--) begin
      tmr_idx_s = tmr_hit_vec_s[k] ? 2'(k) : tmr_idx_s;
    end
    if (in_range(cpu_addr, DM_BASE, DM_LIMIT)) begin
      sel_s = SEL_DM;
    end else if (|tmr_hit_vec_s) begin
      sel_s = SEL_TMR;
    end else if (in_range(cpu_addr, INT_BASE, INT_LIMIT)) begin
      sel_s = SEL_INT;
    end else if (in_range(cpu_addr, CTL_BASE, CTL_BASE + 32'd15)) begin
      sel_s = SEL_CTL;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // A store with a load request is a store; a flushed access still counts as a bus error.
  assign access_s      = cpu_rd | (|cpu_byteen);
  assign wr_s          = (|cpu_byteen) & ~req;
  assign rd_s          = cpu_rd & ~(|cpu_byteen);
  assign err_s         = access_s & (sel_s == SEL_NONE);
  assign ctl_wr_s      = wr_s & (sel_s == SEL_CTL);
  assign ctl_off_s     = cpu_addr[3:2];
  assign m_data_byteen = (wr_s && (sel_s == SEL_DM))  ? cpu_byteen : 4'h0;
  assign m_int_byteen  = (wr_s && (sel_s == SEL_INT)) ? cpu_byteen : 4'h0;

  // Interrupt source vector: timers in the low bits, the external line just above them.
  always_comb begin
    src_s              = 6'h00;
    src_s[N_TIMER-1:0] = tmr_irq;
    src_s[N_TIMER]     = int_irq;
  end

  assign ipend_set_s = src_s & ~src_r;
  assign ipend_clr_s = (ctl_wr_s && (ctl_off_s == 2'd1)) ? cpu_wdata[5:0] : 6'h00;
  assign HWInt       = (src_s | ipend_r) & imask_r;

  // Control register read value, captured alongside the decode on a load.
  always_comb begin
    case (ctl_off_s)
      2'd0:    ctl_rd_s = {26'd0, imask_r};
      2'd1:    ctl_rd_s = {26'd0, ipend_r};
      2'd2:    ctl_rd_s = erraddr_r;
      2'd3:    ctl_rd_s = {16'd0, errcnt_r};
      default: ctl_rd_s = 32'h0000_0000;
    endcase
  end

  // Control block state: mask, sticky pending (set beats clear), bus-error capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      imask_r   <= 6'h3F;
      ipend_r   <= 6'h00;
      src_r     <= 6'h00;
      erraddr_r <= 32'h0000_0000;
      errcnt_r  <= 16'h0000;
    end else begin
      src_r   <= src_s;
      ipend_r <= (ipend_r & ~ipend_clr_s) | ipend_set_s;
      if (ctl_wr_s && (ctl_off_s == 2'd0)) begin
        imask_r <= cpu_wdata[5:0];
      end else begin
        imask_r <= imask_r;
      end
      if (err_s) begin
        erraddr_r <= cpu_addr;
        errcnt_r  <= (errcnt_r == 16'hFFFF) ? errcnt_r : errcnt_r + 16'd1;
      end else if (ctl_wr_s && (ctl_off_s == 2'd3)) begin
        errcnt_r  <= 16'h0000;
      end else begin
        errcnt_r  <= errcnt_r;
      end
    end
  end

  // Read request pipeline: one-cycle latency, one request per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_r     <= SEL_NONE;
      tmr_idx_r <= 2'd0;
      ctl_r     <= 32'h0000_0000;
      rvalid_r  <= 1'b0;
    end else begin
      rvalid_r <= rd_s;
      if (rd_s) begin
        sel_r     <= sel_s;
        tmr_idx_r <= tmr_idx_s;
        ctl_r     <= ctl_rd_s;
      end else begin
        sel_r     <= sel_r;
        tmr_idx_r <= tmr_idx_r;
        ctl_r     <= ctl_r;
      end
    end
  end

  assign cpu_rvalid = rvalid_r;

  // Response mux on the registered select; INT and unmapped loads return zero.
  always_comb begin
    tmr_rdata_s = 32'h0000_0000;
    for (int k = 0; k < N_TIMER; k++) begin
      tmr_rdata_s = (tmr_idx_r == 2'(k)) ? tmr_dout[32*k +: 32] : tmr_rdata_s;
    end
    case (sel_r)
      SEL_DM:  cpu_rdata = m_data_rdata;
      SEL_TMR: cpu_rdata = tmr_rdata_s;
      SEL_CTL: cpu_rdata = ctl_r;
      default: cpu_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_sys_bridge.sv
// Directed bench for sys_bridge: read responses are checked against a queue of
// expected data; strobes, HWInt and control registers against bench-derived values.
module tb_sys_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [3:0]  cpu_byteen = 4'h0;
  logic        cpu_rd = 1'b0;
  logic        req = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [5:0]  HWInt;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata = 32'h0;
  logic [59:0] tmr_addr;
  logic [63:0] tmr_din;
  logic [1:0]  tmr_we;
  logic [63:0] tmr_dout = 64'h0;
  logic [1:0]  tmr_irq = 2'b00;
  logic        int_irq = 1'b0;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;

  localparam logic [31:0] CTL = 32'h0000_7F40;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  sys_bridge dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteen(cpu_byteen), .cpu_rd(cpu_rd), .req(req), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .HWInt(HWInt), .m_data_addr(m_data_addr),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata), .tmr_addr(tmr_addr), .tmr_din(tmr_din),
    .tmr_we(tmr_we), .tmr_dout(tmr_dout), .tmr_irq(tmr_irq), .int_irq(int_irq),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen)
  );

  always #5 clk = ~clk;

  // Synchronous slave models: data is a tag plus the sampled address.
  always @(posedge clk) begin
    m_data_rdata    <= {16'hD000, m_data_addr[15:0]};
    tmr_dout[31:0]  <= {16'hA000, tmr_addr[13:0], 2'b00};
    tmr_dout[63:32] <= {16'hB001, tmr_addr[43:30], 2'b00};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one cycle; check the valid strobe and pop/compare on a response.
  task automatic step(input string tag);
    logic        rd_now;
    logic [31:0] e;
    rd_now = cpu_rd && (cpu_byteen == 4'h0) && reset;
    @(posedge clk);
    #1;
    check({tag, "_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, rd_now});
    if (cpu_rvalid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, cpu_rdata, e);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    cpu_addr   = addr;
    cpu_rd     = 1'b1;
    cpu_byteen = 4'h0;
    req        = 1'b0;
    if (reset) exp_q.push_back(exp);
    step(tag);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                    input logic rq, input string tag);
    cpu_addr   = addr;
    cpu_wdata  = data;
    cpu_rd     = 1'b0;
    cpu_byteen = be;
    req        = rq;
    step(tag);
  endtask

  task automatic idle();
    cpu_rd     = 1'b0;
    cpu_byteen = 4'h0;
    req        = 1'b0;
    step("idle");
  endtask

  initial begin
    // Reset state
    step("rst0");
    step("rst1");
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_hwint", {26'd0, HWInt}, 32'h0);
    reset = 1'b1;
    idle();

    rd(CTL + 32'h0, 32'h0000_003F, "rd_imask");
    rd(CTL + 32'h8, 32'h0000_0000, "rd_erraddr");
    idle();

    // Write strobes and pass-through buses
    cpu_addr = 32'h0000_7F14; cpu_wdata = 32'h1234_5678; cpu_byteen = 4'hF; req = 1'b0; cpu_rd = 1'b1;
    #1;
    check("tmr1_we", {30'd0, tmr_we}, 32'h2);
    check("tmr1_dm_be", {28'd0, m_data_byteen}, 32'h0);
    check("tmr1_din", tmr_din[63:32], 32'h1234_5678);
    check("tmr1_addr", {2'b00, tmr_addr[59:30]}, 32'h0000_1FC5);
    step("tmr1_wr");
    cpu_byteen = 4'h0; cpu_rd = 1'b0;
    #1;
    check("tmr1_we_pulse", {30'd0, tmr_we}, 32'h0);
    step("tmr1_idle");
    cpu_byteen = 4'hF; req = 1'b1;
    #1;
    check("tmr1_req_we", {30'd0, tmr_we}, 32'h0);
    check("tmr1_req_dm_be", {28'd0, m_data_byteen}, 32'h0);
    step("tmr1_req");
    cpu_addr = 32'h0000_0100; cpu_wdata = 32'hCAFE_F00D; cpu_byteen = 4'h3; req = 1'b0;
    #1;
    check("dm_be", {28'd0, m_data_byteen}, 32'h3);
    check("dm_wdata", m_data_wdata, 32'hCAFE_F00D);
    check("dm_tmr_we", {30'd0, tmr_we}, 32'h0);
    step("dm_wr");
    cpu_addr = 32'h0000_7F21; cpu_byteen = 4'h2;
    #1;
    check("int_be", {28'd0, m_int_byteen}, 32'h2);
    check("int_addr", m_int_addr, 32'h0000_7F21);
    step("int_wr");
    idle();

    // Back-to-back loads from different slaves
    rd(32'h0000_1000, 32'hD000_1000, "rd_dm");
    rd(32'h0000_7F04, 32'hA000_7F04, "rd_tmr0");
    rd(32'h0000_7F14, 32'hB001_7F14, "rd_tmr1");
    rd(32'h0000_7F20, 32'h0000_0000, "rd_int");
    rd(32'h0000_2FFC, 32'hD000_2FFC, "rd_dm_top");
    idle();

    // Sticky pending, clear, mask
    tmr_irq = 2'b01;
    #1;
    check("hwint_raw", {26'd0, HWInt}, 32'h01);
    step("irq_pulse");
    tmr_irq = 2'b00;
    #1;
    check("hwint_sticky", {26'd0, HWInt}, 32'h01);
    rd(CTL + 32'h4, 32'h0000_0001, "rd_ipend1");
    wr(CTL + 32'h4, 32'h0000_0001, 4'hF, 1'b0, "clr_ipend");
    check("hwint_cleared", {26'd0, HWInt}, 32'h00);
    wr(CTL + 32'h0, 32'h0000_0000, 4'hF, 1'b0, "imask0");
    tmr_irq = 2'b11; int_irq = 1'b1;
    #1;
    check("hwint_masked", {26'd0, HWInt}, 32'h00);
    idle();
    check("hwint_masked_pend", {26'd0, HWInt}, 32'h00);
    tmr_irq = 2'b00; int_irq = 1'b0;
    rd(CTL + 32'h4, 32'h0000_0007, "rd_ipend7");
    wr(CTL + 32'h4, 32'h0000_003F, 4'hF, 1'b0, "clr_all");
    wr(CTL + 32'h0, 32'h0000_003F, 4'hF, 1'b0, "imask3f");
    check("hwint_unmask", {26'd0, HWInt}, 32'h00);

    // Set beats clear on the same bit
    int_irq = 1'b1;
    wr(CTL + 32'h4, 32'h0000_0004, 4'hF, 1'b0, "set_wins");
    rd(CTL + 32'h4, 32'h0000_0004, "rd_set_wins");
    int_irq = 1'b0;
    wr(CTL + 32'h4, 32'h0000_0004, 4'hF, 1'b0, "clr_bit2");
    rd(CTL + 32'h4, 32'h0000_0000, "rd_ipend0");

    // Bus-error capture and saturation
    wr(32'h0000_9000, 32'h0, 4'hF, 1'b0, "err1");
    wr(32'h0000_9000, 32'h0, 4'hF, 1'b0, "err2");
    wr(32'h0000_9000, 32'h0, 4'hF, 1'b0, "err3");
    rd(CTL + 32'h8, 32'h0000_9000, "rd_erraddr9000");
    rd(CTL + 32'hC, 32'h0000_0003, "rd_errcnt3");
    wr(32'h0000_A000, 32'h0, 4'hF, 1'b1, "err_req");
    rd(CTL + 32'h8, 32'h0000_A000, "rd_erraddrA000");
    rd(CTL + 32'hC, 32'h0000_0004, "rd_errcnt4");
    wr(CTL + 32'hC, 32'h0, 4'h1, 1'b0, "clr_errcnt");
    rd(CTL + 32'hC, 32'h0000_0000, "rd_errcnt0");
    rd(32'h0000_9004, 32'h0000_0000, "rd_unmapped");
    rd(CTL + 32'hC, 32'h0000_0001, "rd_errcnt1");
    cpu_rd = 1'b0;
    force dut.errcnt_r = 16'hFFFF;
    #1;
    release dut.errcnt_r;
    wr(32'h0000_9000, 32'h0, 4'hF, 1'b0, "err_sat");
    rd(CTL + 32'hC, 32'h0000_FFFF, "rd_errcnt_sat");

    // Reset while a response is outstanding
    wr(CTL + 32'h0, 32'h0000_0015, 4'hF, 1'b0, "imask15");
    rd(CTL + 32'h0, 32'h0000_0015, "rd_imask15");
    cpu_addr = CTL + 32'h4;
    reset = 1'b0;
    step("rst_mid");
    reset = 1'b1;
    rd(CTL + 32'h0, 32'h0000_003F, "rd_imask_rst");
    rd(CTL + 32'hC, 32'h0000_0000, "rd_errcnt_rst");
    idle();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
